// File: rtl/screen_clear.sv
// screen_clear: on system reset request, sweeps the dot-matrix frame buffer
// writing CLR_COLOR to every pixel, waits SETTLE_CYC cycles, then reports
// rst_ok back to the top-level state machine for as long as state stays RST.
module screen_clear #(
  parameter int unsigned         H_PIX      = 8,
  parameter int unsigned         V_PIX      = 8,
  parameter int unsigned         ADDR_W     = 6,
  parameter int unsigned         DATA_W     = 3,
  parameter logic [DATA_W-1:0]   CLR_COLOR  = '0,
  parameter int unsigned         SETTLE_CYC = 4,
  // Encoding of the RST code from st_state.v (RST is the first code, 3'd0)
  parameter logic [2:0]          ST_RST     = 3'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        state,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              rst_ok
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SETTLE,
    DONE
  } fsm_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(H_PIX * V_PIX - 1);
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);

  fsm_t              fsm_q, fsm_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        settle_q, settle_d;
  logic              en_d, busy_d, ok_d;
  logic [DATA_W-1:0] data_d;
  logic              is_rst;

  // Next-state and next-output decode; wr_addr doubles as the clear counter
  // and every output flop is loaded from the decoded next state.
  always_comb begin
    fsm_d    = fsm_q;
    addr_d   = wr_addr;
    settle_d = settle_q;
    is_rst   = (state == ST_RST);

    unique case (fsm_q)
      IDLE: begin
        addr_d   = '0;
        settle_d = '0;
        if (is_rst) fsm_d = CLEAR;
      end
      CLEAR: begin
        if (!is_rst) begin
          // Abort wins; a write accepted this same cycle is simply finished.
          fsm_d  = IDLE;
          addr_d = '0;
        end else if (wr_en && wr_ready) begin
          if (wr_addr == LAST_ADDR) begin
            fsm_d    = SETTLE;
            addr_d   = '0;
            settle_d = '0;
          end else begin
            addr_d = wr_addr + ADDR_W'(1);
          end
        end
      end
      SETTLE: begin
        if (!is_rst) begin
          fsm_d    = IDLE;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          fsm_d    = DONE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      DONE: begin
        if (!is_rst) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    en_d   = (fsm_d == CLEAR);
    data_d = en_d ? CLR_COLOR : '0;
    busy_d = (fsm_d == CLEAR) || (fsm_d == SETTLE);
    ok_d   = (fsm_d == DONE);
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      settle_q <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      rst_ok   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      settle_q <= settle_d;
      wr_en    <= en_d;
      wr_addr  <= addr_d;
      wr_data  <= data_d;
      busy     <= busy_d;
      rst_ok   <= ok_d;
    end
  end

endmodule

// File: tb/tb_screen_clear.sv
// tb_screen_clear: directed vector table plus hand-written multi-cycle
// sequences for full clear, stall, abort, mid-clear reset and idle states.
module tb_screen_clear;

  localparam logic [2:0] RST   = 3'd0;
  localparam logic [2:0] SLEEP = 3'd1;
  localparam logic [2:0] DRAW  = 3'd3;
  localparam logic [2:0] ERASE = 3'd5;
  localparam logic [2:0] STOP  = 3'd7;
  localparam logic [2:0] CLR   = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state;
  logic       wr_ready;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [2:0] wr_data;
  logic       busy;
  logic       rst_ok;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  screen_clear #(
    .H_PIX(8),
    .V_PIX(8),
    .ADDR_W(6),
    .DATA_W(3),
    .CLR_COLOR(CLR),
    .SETTLE_CYC(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .state(state),
    .wr_ready(wr_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .rst_ok(rst_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  typedef struct {
    logic       r;
    logic [2:0] st;
    logic       rdy;
    logic       en;
    logic [5:0] addr;
    logic [2:0] data;
    logic       b;
    logic       ok;
  } vec_t;

  vec_t tbl [17];

  // Drive inputs, take one clock edge, sample #1 later.
  task automatic step(input logic r, input logic [2:0] st, input logic rdy);
    rst_n    = r;
    state    = st;
    wr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input logic en, input logic [5:0] a,
                           input logic [2:0] d, input logic b, input logic ok);
    nvec++;
    if ({wr_en, wr_addr, wr_data, busy, rst_ok} !== {en, a, d, b, ok}) begin
      nerr++;
      $display("FAIL %s: got en=%0b addr=%0d data=%0d busy=%0b ok=%0b, expected en=%0b addr=%0d data=%0d busy=%0b ok=%0b",
               nm, wr_en, wr_addr, wr_data, busy, rst_ok, en, a, d, b, ok);
    end
  endtask

  task automatic chk_clear(input string nm, input int unsigned a);
    check_out(nm, 1'b1, 6'(a), CLR, 1'b1, 1'b0);
  endtask

  task automatic chk_idle(input string nm);
    check_out(nm, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_settle(input string nm);
    check_out(nm, 1'b0, 6'd0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic chk_done(input string nm);
    check_out(nm, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    state    = DRAW;
    wr_ready = 1'b1;

    //         r     st     rdy   en    addr  data  busy  ok
    tbl[0]  = '{1'b0, DRAW,  1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, RST,   1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, DRAW,  1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, ERASE, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, RST,   1'b1, 1'b1, 6'd0, CLR,  1'b1, 1'b0};
    tbl[5]  = '{1'b1, RST,   1'b0, 1'b1, 6'd0, CLR,  1'b1, 1'b0};
    tbl[6]  = '{1'b1, RST,   1'b0, 1'b1, 6'd0, CLR,  1'b1, 1'b0};
    tbl[7]  = '{1'b1, RST,   1'b1, 1'b1, 6'd1, CLR,  1'b1, 1'b0};
    tbl[8]  = '{1'b1, RST,   1'b1, 1'b1, 6'd2, CLR,  1'b1, 1'b0};
    tbl[9]  = '{1'b1, STOP,  1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, STOP,  1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, RST,   1'b1, 1'b1, 6'd0, CLR,  1'b1, 1'b0};
    tbl[12] = '{1'b1, RST,   1'b1, 1'b1, 6'd1, CLR,  1'b1, 1'b0};
    tbl[13] = '{1'b0, RST,   1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, RST,   1'b1, 1'b1, 6'd0, CLR,  1'b1, 1'b0};
    tbl[15] = '{1'b1, SLEEP, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, SLEEP, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].st, tbl[i].rdy);
      check_out($sformatf("tbl[%0d]", i), tbl[i].en, tbl[i].addr, tbl[i].data,
                tbl[i].b, tbl[i].ok);
    end

    // Non-RST state keeps the block quiet.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, DRAW, 1'b1);
      chk_idle("draw_idle");
    end

    // Full clear with wr_ready tied high: 64 writes, 4 settle, then rst_ok.
    step(1'b1, RST, 1'b1);
    chk_clear("full_first", 0);
    for (int unsigned i = 1; i < 64; i++) begin
      step(1'b1, RST, 1'b1);
      chk_clear("full_seq", i);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, RST, 1'b1);
      chk_settle("full_settle");
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, RST, 1'b1);
      chk_done("full_done");
    end
    step(1'b1, SLEEP, 1'b1);
    chk_idle("done_to_sleep");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, SLEEP, 1'b1);
      chk_idle("sleep_idle");
    end

    // Stall at address 10 for three cycles.
    step(1'b1, RST, 1'b1);
    chk_clear("stall_first", 0);
    for (int unsigned i = 1; i <= 10; i++) begin
      step(1'b1, RST, 1'b1);
      chk_clear("stall_pre", i);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, RST, 1'b0);
      chk_clear("stall_hold", 10);
    end
    for (int unsigned i = 11; i < 64; i++) begin
      step(1'b1, RST, 1'b1);
      chk_clear("stall_post", i);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, RST, 1'b1);
      chk_settle("stall_settle");
    end
    step(1'b1, RST, 1'b1);
    chk_done("stall_done");
    step(1'b1, STOP, 1'b1);
    chk_idle("stall_exit");

    // Abort at address 20, stay out, then re-enter from address 0.
    step(1'b1, RST, 1'b1);
    chk_clear("abort_first", 0);
    for (int unsigned i = 1; i <= 20; i++) begin
      step(1'b1, RST, 1'b1);
      chk_clear("abort_pre", i);
    end
    step(1'b1, STOP, 1'b1);
    chk_idle("abort_stop");
    for (int i = 0; i < 80; i++) begin
      step(1'b1, STOP, 1'b1);
      chk_idle("abort_hold");
    end
    step(1'b1, RST, 1'b1);
    chk_clear("abort_restart", 0);

    // Reset pulse at address 30, release with RST held.
    for (int unsigned i = 1; i <= 30; i++) begin
      step(1'b1, RST, 1'b1);
      chk_clear("rstp_pre", i);
    end
    step(1'b0, RST, 1'b1);
    chk_idle("rstp_low");
    step(1'b1, RST, 1'b1);
    chk_clear("rstp_restart", 0);

    // Abort during settle, then re-entry restarts the full clear.
    for (int unsigned i = 1; i < 64; i++) begin
      step(1'b1, RST, 1'b1);
      chk_clear("sabort_pre", i);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, RST, 1'b1);
      chk_settle("sabort_settle");
    end
    step(1'b1, STOP, 1'b1);
    chk_idle("sabort_stop");
    step(1'b1, STOP, 1'b1);
    chk_idle("sabort_hold");
    step(1'b1, RST, 1'b1);
    chk_clear("sabort_restart", 0);
    step(1'b1, RST, 1'b1);
    chk_clear("sabort_next", 1);
    step(1'b1, SLEEP, 1'b1);
    chk_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/screen_clear.md
SCREEN_CLEAR -- requirements
Module: screen_clear

Interface
REQ-001 Parameter H_PIX, default 8, horizontal pixel count of the dot-matrix frame buffer.
REQ-002 Parameter V_PIX, default 8, vertical pixel count.
REQ-003 Parameter ADDR_W, default 6, frame-buffer address width; SHALL satisfy 2^ADDR_W >= H_PIX*V_PIX.
REQ-004 Parameter DATA_W, default 3, pixel colour width (RGB).
REQ-005 Parameter CLR_COLOR, default 3'b000, value written to every pixel during clear.
REQ-006 Parameter SETTLE_CYC, default 4, wait cycles between the last accepted write and rst_ok; range 1..255.
REQ-007 clk  input  1  system clock; single clock domain.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 state  input  3  top-level system state, encoded with the `RST/`SLEEP/`LIGHT/`DRAW/`WRITE/`ERASE/`COLOR/`STOP macros from st_state.v.
REQ-010 wr_ready  input  1  frame-buffer port accepts the write presented this cycle.
REQ-011 wr_en  output  1  write request to frame buffer.
REQ-012 wr_addr  output  ADDR_W  pixel address, row-major (y*H_PIX + x).
REQ-013 wr_data  output  DATA_W  pixel data.
REQ-014 busy  output  1  clear or settle in progress.
REQ-015 rst_ok  output  1  system reset complete; returned to the top-level state machine.

Function
REQ-016 Internal FSM states: IDLE, CLEAR, SETTLE, DONE; all outputs registered.
REQ-017 IDLE: if state==`RST, go to CLEAR with address counter 0; else remain.
REQ-018 CLEAR: wr_en=1, wr_addr=counter, wr_data=CLR_COLOR; counter advances by 1 only in a cycle where wr_en&&wr_ready.
REQ-019 While wr_ready=0, wr_en, wr_addr, wr_data SHALL hold stable.
REQ-020 Accept at address H_PIX*V_PIX-1: wr_en deasserts next cycle, settle counter loaded with 0, go to SETTLE; counter never exceeds H_PIX*V_PIX-1 (no wrap).
REQ-021 SETTLE: counter increments each cycle; after SETTLE_CYC cycles in SETTLE, go to DONE.
REQ-022 DONE: rst_ok=1 while state==`RST; when state!=`RST, rst_ok=0 and go to IDLE next cycle.
REQ-023 busy=1 exactly in CLEAR and SETTLE.
REQ-024 Latency: state becomes `RST in cycle N while IDLE -> wr_en=1 with wr_addr=0 in cycle N+1.
REQ-025 With wr_ready tied 1: H_PIX*V_PIX consecutive write cycles, then SETTLE_CYC cycles, then rst_ok=1.
REQ-026 Abort: state leaves `RST during CLEAR or SETTLE (e.g. `STOP) -> wr_en=0, busy=0 next cycle, go to IDLE, rst_ok stays 0; partial clear not resumed.
REQ-027 Re-entry: state returns to `RST after any abort or completion -> full clear restarts from address 0.
REQ-028 A write accepted in the same cycle as abort counts as completed; no further writes issued.
REQ-029 Unlisted/illegal state codes treated as non-`RST.

Reset
REQ-030 rst_n=0 at a clk edge: FSM=IDLE, counters=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, rst_ok=0.
REQ-031 Reset overrides all other inputs, including mid-CLEAR; no write issued in the cycle after reset is sampled.
REQ-032 rst_n released with state already `RST: clear begins per REQ-024.

Verification
REQ-033 Defaults, wr_ready=1, state=`RST at cycle 0 -> wr_en cycles 1..64, addr 0..63 in order, data 0; busy 1..68; rst_ok=1 from cycle 69.
REQ-034 wr_ready=0 for 3 cycles at addr 10 -> addr 10 held 4 cycles, no skipped or duplicated address, rst_ok delayed by 3.
REQ-035 state to `STOP at addr 20 -> wr_en=0 next cycle, rst_ok never asserts; state back to `RST -> writes restart at addr 0.
REQ-036 rst_ok=1, state to `SLEEP -> rst_ok=0 next cycle, FSM IDLE, no writes.
REQ-037 rst_n pulsed low at addr 30 -> all outputs 0 next cycle; on release with state=`RST, clear restarts at addr 0.
REQ-038 state=`DRAW after reset -> wr_en, busy, rst_ok stay 0 for 100 cycles.
